// File: rtl/sram_arb.sv
// ---------------------------------------------------------------------------
// sram_arb
//   Arbitrates two requesters for one single-port SRAM macro with active-low
//   cen/wen/oen strobes. Port 0 is the bus-side controller, port 1 the
//   BIST/march engine. Only one access is in flight at a time. SRAM strobes,
//   address and write data are all driven from registers. Read data goes back
//   only to the port that issued the read.
//
//   Sequence per access: IDLE (arbitrate) -> ACCESS (strobes low, grant pulse)
//   -> IDLE for writes, or -> RWAIT for RD_LAT cycles -> IDLE for reads. The
//   rvalid pulse is raised in the IDLE cycle that follows RWAIT.
//
// Parameters
//   AW         SRAM address width
//   DW         SRAM data width
//   RD_LAT     cycles from the edge that samples s_cen=0 (read) until s_qdata
//              is valid, 1..7
//   FIXED_PRIO 0 = round-robin, 1 = port 0 always wins a tie
//
// Ports
//   clk, reset_n           clock and synchronous active-low reset
//   req0/1, we0/1          request and write/read select, held until granted
//   addr0/1, wdata0/1      access address and write data
//   gnt0/1                 one-cycle pulse in the cycle the strobes are active
//   rvalid0/1, rdata0/1    read-return pulse; rdata holds until the next read
//   busy                   high whenever the arbiter is not in IDLE
//   s_cen/s_wen/s_oen      SRAM strobes, active low
//   s_addr, s_ddata        SRAM address and write data
//   s_qdata                SRAM read data
// ---------------------------------------------------------------------------
module sram_arb #(
    parameter int AW         = 10,
    parameter int DW         = 8,
    parameter int RD_LAT     = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          busy,
    output logic          s_cen,
    output logic          s_wen,
    output logic          s_oen,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_ddata,
    input  logic [DW-1:0] s_qdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RWAIT  = 2'd2
    } state_e;

    // Wide enough for RD_LAT-1 with RD_LAT up to 7.
    localparam int CW = 3;

    state_e          state_q, state_d;
    logic            last_port_q, last_port_d;
    logic            port_q, port_d;
    logic            we_q, we_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            s_cen_q, s_cen_d;
    logic            s_wen_q, s_wen_d;
    logic            s_oen_q, s_oen_d;
    logic [AW-1:0]   s_addr_q, s_addr_d;
    logic [DW-1:0]   s_ddata_q, s_ddata_d;
    logic            gnt0_q, gnt0_d;
    logic            gnt1_q, gnt1_d;
    logic            rvalid0_q, rvalid0_d;
    logic            rvalid1_q, rvalid1_d;
    logic [DW-1:0]   rdata0_q, rdata0_d;
    logic [DW-1:0]   rdata1_q, rdata1_d;
    logic            busy_q;

    // Winner of the current IDLE cycle. On a tie, round-robin hands the slot
    // to the port that did not win last time; last_port resets to 1 so the
    // very first tie goes to port 0.
    logic            win;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    assign win       = (req0 && req1) ? ((FIXED_PRIO != 0) ? 1'b0 : ~last_port_q) : req1;
    assign sel_we    = win ? we1    : we0;
    assign sel_addr  = win ? addr1  : addr0;
    assign sel_wdata = win ? wdata1 : wdata0;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        last_port_d = last_port_q;
        port_d      = port_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        s_cen_d     = 1'b1;
        s_wen_d     = 1'b1;
        s_oen_d     = 1'b1;
        s_addr_d    = s_addr_q;
        s_ddata_d   = s_ddata_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Strobes for the ACCESS cycle are loaded here so they
                    // come straight out of registers during that cycle.
                    port_d      = win;
                    we_d        = sel_we;
                    last_port_d = win;
                    s_cen_d     = 1'b0;
                    s_wen_d     = ~sel_we;
                    s_oen_d     = sel_we;
                    s_addr_d    = sel_addr;
                    if (sel_we) begin
                        s_ddata_d = sel_wdata;
                    end
                    gnt0_d      = ~win;
                    gnt1_d      = win;
                    state_d     = ACCESS;
                end
            end

            ACCESS: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    // Output enable stays low through the whole read wait.
                    s_oen_d = 1'b0;
                    cnt_d   = CW'(RD_LAT - 1);
                    state_d = RWAIT;
                end
            end

            RWAIT: begin
                if (cnt_q != '0) begin
                    s_oen_d = 1'b0;
                    cnt_d   = cnt_q - 1'b1;
                end else begin
                    if (port_q) begin
                        rdata1_d  = s_qdata;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = s_qdata;
                        rvalid0_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            last_port_q <= 1'b1;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            s_cen_q     <= 1'b1;
            s_wen_q     <= 1'b1;
            s_oen_q     <= 1'b1;
            s_addr_q    <= '0;
            s_ddata_q   <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_port_q <= last_port_d;
            port_q      <= port_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            s_cen_q     <= s_cen_d;
            s_wen_q     <= s_wen_d;
            s_oen_q     <= s_oen_d;
            s_addr_q    <= s_addr_d;
            s_ddata_q   <= s_ddata_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign busy    = busy_q;
    assign s_cen   = s_cen_q;
    assign s_wen   = s_wen_q;
    assign s_oen   = s_oen_q;
    assign s_addr  = s_addr_q;
    assign s_ddata = s_ddata_q;

endmodule
